cell_pos_reader: RTL and testbench

CELL_POS_READER -- requirements
Module: cell_pos_reader

---
 rtl/md_pkg.sv | 15 +
 rtl/pos_prefetch_fifo.sv | 54 +++++
 rtl/cell_pos_reader.sv | 181 ++++++++++++++++++
 tb/tb_cell_pos_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared constants and FSM state type for the cell position reader.
package md_pkg;

  localparam int unsigned READ_LATENCY = 2;
  localparam int unsigned FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/pos_prefetch_fifo.sv
// Show-ahead FIFO holding prefetched particle records; exposes its occupancy.
module pos_prefetch_fifo
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 105,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 wdata,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 rdata,
  output logic                             empty,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCCW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occupancy == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((occupancy != OCCW'(DEPTH)) | do_pop);

  // Storage array; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTRW'(DEPTH-1)) ? '0 : wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTRW'(DEPTH-1)) ? '0 : rd_ptr + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCCW'(1);
        2'b01:   occupancy <= occupancy - OCCW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/cell_pos_reader.sv
// Reads a cell's particle count from RAM address 0, then streams particles
// 1..N through a prefetch FIFO with valid/ready flow control.
module cell_pos_reader
  import md_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int unsigned FW   = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned OW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW   = ADDR_WIDTH + 1;
  localparam int unsigned WW   = $clog2(READ_LATENCY + 1);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
  localparam logic [PW-1:0] N_MAX = PW'(PARTICLE_NUM - 1);

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt;
  logic [PW-1:0]   n_cnt;
  logic [PW-1:0]   next_pid;
  logic            rd_part;
  logic            rd_last;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [ADDR_WIDTH-1:0]   pipe_pid  [READ_LATENCY];
  logic                    pipe_last [READ_LATENCY];

  logic [PW-1:0]   n_raw, n_clamp, issue_n;
  logic            n_ovf;
  logic            wait_last;
  logic            cnt_rd, issue, issue_last, credit_ok, pop;
  logic [CW-1:0]   fill;
  logic            fifo_empty;
  logic [OW-1:0]   occupancy;
  logic [FW-1:0]   head;

  assign n_raw     = PW'(ram_q[ADDR_WIDTH-1:0]);
  assign n_ovf     = (n_raw > N_MAX);
  assign n_clamp   = n_ovf ? N_MAX : n_raw;
  assign wait_last = (wait_cnt == WW'(READ_LATENCY - 1));
  assign pop       = out_valid & out_ready;
  assign busy      = (state != IDLE);
  assign ram_wren  = 1'b0;

  // Projected in-flight + buffered count for the cycle the next read would be
  // visible on ram_rden; counting this cycle's pop keeps full throughput.
  always_comb begin
    fill = CW'(rd_part) + CW'(occupancy);
    for (int unsigned i = 0; i < READ_LATENCY; i++) fill = fill + CW'(pipe_vld[i]);
    credit_ok = ((fill - CW'(pop)) < CW'(FIFO_DEPTH));
  end

  // Next-state, read issue and done decode. The first particle read is decided
  // in the final WAIT_CNT cycle straight from ram_q so it lands at s+4.
  always_comb begin
    state_nxt = state;
    cnt_rd    = 1'b0;
    issue     = 1'b0;
    issue_n   = n_cnt;
    done      = 1'b0;
    case (state)
      IDLE:     if (start) begin
                  cnt_rd    = 1'b1;
                  state_nxt = RD_CNT;
                end
      RD_CNT:   state_nxt = WAIT_CNT;
      WAIT_CNT: if (wait_last) begin
                  issue_n = n_clamp;
                  if (n_clamp == '0) state_nxt = DRAIN;
                  else begin
                    issue     = 1'b1;
                    state_nxt = STREAM;
                  end
                end
      STREAM:   if (next_pid > n_cnt) state_nxt = DRAIN;
                else if (credit_ok) begin
                  issue = 1'b1;
                  if (next_pid == n_cnt) state_nxt = DRAIN;
                end
      DRAIN:    if (fifo_empty && !rd_part && (pipe_vld == '0)) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
                end
      default:  state_nxt = IDLE;
    endcase
    issue_last = (next_pid == issue_n);
  end

  // FSM state, read request registers, count capture and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      n_cnt       <= '0;
      next_pid    <= '0;
      count_err   <= 1'b0;
      ram_address <= '0;
      ram_rden    <= 1'b0;
      rd_part     <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ram_rden <= cnt_rd | issue;
      rd_part  <= issue;
      rd_last  <= issue & issue_last;
      if (cnt_rd) begin
        ram_address <= '0;
        count_err   <= 1'b0;
        next_pid    <= PW'(1);
        wait_cnt    <= '0;
      end
      if (issue) begin
        ram_address <= next_pid[ADDR_WIDTH-1:0];
        next_pid    <= next_pid + PW'(1);
      end
      if (state == WAIT_CNT) begin
        wait_cnt <= wait_cnt + WW'(1);
        if (wait_last) begin
          n_cnt     <= n_clamp;
          count_err <= n_ovf;
        end
      end
    end
  end

  // Tag pipeline aligning pid/last with RAM data returning READ_LATENCY later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_pid[i]  <= '0;
        pipe_last[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0]  <= rd_part;
      pipe_pid[0]  <= ram_address;
      pipe_last[0] <= rd_last;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_pid[i]  <= pipe_pid[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  pos_prefetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld[READ_LATENCY-1]),
    .wdata     ({ram_q, pipe_pid[READ_LATENCY-1], pipe_last[READ_LATENCY-1]}),
    .pop       (pop),
    .rdata     (head),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign out_valid = ~fifo_empty;
  assign out_pos   = fifo_empty ? '0 : head[FW-1 -: DATA_WIDTH];
  assign out_pid   = fifo_empty ? '0 : head[ADDR_WIDTH:1];
  assign out_last  = fifo_empty ? 1'b0 : head[0];

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed-plus-random bench for cell_pos_reader with a behavioural RAM model.
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic          busy, done, count_err, ram_rden, ram_wren, out_valid, out_last;
  logic [AW-1:0] ram_address, out_pid;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] out_pos;
  logic [DW-1:0] rd_stage = '0;
  logic [DW-1:0] mem [256];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cell_pos_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .PARTICLE_NUM (PN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .count_err   (count_err),
    .ram_address (ram_address),
    .ram_rden    (ram_rden),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pos     (out_pos),
    .out_pid     (out_pid),
    .out_last    (out_last)
  );

  // Cell RAM: data for a read in cycle c is presented throughout cycle c+2.
  always @(posedge clk) begin
    if (ram_rden) rd_stage <= mem[ram_address];
    ram_q <= rd_stage;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  128'(busy),        128'(0));
    check({tag, "_done"},  128'(done),        128'(0));
    check({tag, "_valid"}, 128'(out_valid),   128'(0));
    check({tag, "_pos"},   128'(out_pos),     128'(0));
    check({tag, "_pid"},   128'(out_pid),     128'(0));
    check({tag, "_last"},  128'(out_last),    128'(0));
    check({tag, "_rden"},  128'(ram_rden),    128'(0));
    check({tag, "_addr"},  128'(ram_address), 128'(0));
    check({tag, "_err"},   128'(count_err),   128'(0));
    check({tag, "_wren"},  128'(ram_wren),    128'(0));
  endtask

  // One cell transaction. rand_ready: random backpressure; restart_k: cycle of a
  // stray start pulse (0 = none); abort_beats: reset after that many beats (0 = none).
  task automatic run_cell(input int n_raw, input bit rand_ready, input int restart_k,
                          input int abort_beats);
    int n_eff, k, beats, issued, popped, first_k, done_k;
    bit err_exp, done_seen, aborted, hs;
    logic          pv_stall;
    logic [DW-1:0] pv_pos;
    logic [AW-1:0] pv_pid;
    logic          pv_last;
    n_eff   = (n_raw > PN - 1) ? PN - 1 : n_raw;
    err_exp = (n_raw > PN - 1);
    mem[0]  = DW'(n_raw);
    for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    k = 0; beats = 0; issued = 0; popped = 0; first_k = -1; done_k = -1;
    done_seen = 0; aborted = 0; pv_stall = 0; pv_pos = '0; pv_pid = '0; pv_last = 0;
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    while (!done_seen && !aborted && k < 3000) begin
      @(negedge clk);
      k++;
      start     = (k == restart_k);
      out_ready = rand_ready ? (($urandom % 3) != 0) : 1'b1;
      check("wren", 128'(ram_wren), 128'(0));
      check("busy", 128'(busy), 128'(1));
      if (k == 1) begin
        check("cnt_rden", 128'(ram_rden), 128'(1));
        check("cnt_addr", 128'(ram_address), 128'(0));
        check("err_clear", 128'(count_err), 128'(0));
      end else if (k < 4) begin
        check("early_rden", 128'(ram_rden), 128'(0));
      end else if (ram_rden) begin
        check("rd_addr", 128'(ram_address), 128'(issued + 1));
        check("rd_credit", 128'((issued - popped) < 4), 128'(1));
        issued++;
      end
      if (pv_stall) begin
        check("stall_valid", 128'(out_valid), 128'(1));
        check("stall_pos",   128'(out_pos),   128'(pv_pos));
        check("stall_pid",   128'(out_pid),   128'(pv_pid));
        check("stall_last",  128'(out_last),  128'(pv_last));
      end
      if (out_valid && first_k < 0) first_k = k;
      hs = out_valid && out_ready;
      if (hs) begin
        beats++;
        check("pid",  128'(out_pid),  128'(beats));
        check("pos",  128'(out_pos),  128'(mem[beats & 255]));
        check("last", 128'(out_last), 128'(beats == n_eff));
        popped++;
      end
      pv_stall = out_valid && !out_ready;
      pv_pos   = out_pos;
      pv_pid   = out_pid;
      pv_last  = out_last;
      if (done) begin
        done_seen = 1;
        done_k    = k;
        check("done_beats", 128'(beats), 128'(n_eff));
        check("done_reads", 128'(issued), 128'(n_eff));
        check("done_err", 128'(count_err), 128'(err_exp));
        check("done_valid", 128'(out_valid), 128'(0));
      end
      if (abort_beats != 0 && hs && beats == abort_beats) aborted = 1;
    end
    out_ready = 1'b1;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check("post_rst_valid", 128'(out_valid), 128'(0));
        check("post_rst_busy", 128'(busy), 128'(0));
      end
      return;
    end
    check("done_seen", 128'(done_seen), 128'(1));
    if (!rand_ready) begin
      check("done_cycle", 128'(done_k), 128'((n_eff == 0) ? 4 : 7 + n_eff));
      if (n_eff > 0) check("first_valid_cycle", 128'(first_k), 128'(7));
    end
    if (n_eff == 0) check("empty_no_valid", 128'(first_k < 0), 128'(1));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("tail_busy",  128'(busy),      128'(0));
      check("tail_done",  128'(done),      128'(0));
      check("tail_valid", 128'(out_valid), 128'(0));
      check("tail_rden",  128'(ram_rden),  128'(0));
      check("tail_wren",  128'(ram_wren),  128'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_cell(5, 1'b0, 0, 0);      // full throughput
    run_cell(0, 1'b0, 0, 0);      // empty cell
    run_cell(250, 1'b0, 0, 0);    // count overflow, clamped to 219
    run_cell(10, 1'b1, 0, 0);     // random backpressure
    for (int r = 0; r < 3; r++) run_cell(int'($urandom_range(1, 30)), 1'b1, 0, 0);
    run_cell(10, 1'b0, 0, 3);     // reset after the 3rd beat
    run_cell(2, 1'b0, 0, 0);      // clean restart after reset
    run_cell(8, 1'b1, 9, 0);      // stray start while streaming

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
